// File: rtl/distance_pkg.sv
// Purpose: constants shared by the ultrasonic controller, distance filter and display path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package distance_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int CLK_HZ             = 12000000;

    // Filter FSM encoding
    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_AVG   = 2'd1;
    localparam logic [1:0] ST_STALE = 2'd2;

endpackage

// File: rtl/distance_sample_ring.sv
// Purpose: ring buffer of the last 2^LOG2_DEPTH accepted samples with a running sum and fill count.
// Latency: sum/fill_cnt reflect a push at the edge that accepts it (1 cycle).
// Backpressure: none; a push is taken every cycle it is asserted, clear wins over push.
module distance_sample_ring #(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2_DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push,
    input  logic                             clear,
    input  logic [DATA_WIDTH-1:0]            data_in,
    output logic [DATA_WIDTH+LOG2_DEPTH-1:0] sum,
    output logic [LOG2_DEPTH:0]              fill_cnt
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SW    = DATA_WIDTH + LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] FILL_MAX = (LOG2_DEPTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] ring_q [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr;

    // Replace the oldest entry and keep the sum equal to the total of all entries
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                ring_q[i] <= '0;
            end
            wr_ptr   <= '0;
            sum      <= '0;
            fill_cnt <= '0;
        end else if (push) begin
            sum            <= sum - SW'(ring_q[wr_ptr]) + SW'(data_in);
            ring_q[wr_ptr] <= data_in;
            wr_ptr         <= wr_ptr + 1'b1;
            if (fill_cnt != FILL_MAX) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/distance_filter.sv
// Purpose: range-checks raw HC-SR04 distances, averages accepted ones, flags echo loss.
// Latency: 2 cycles from sample_valid to filtered_valid.
// Backpressure: none; back-to-back strobes each yield one in-order pulse, rejects yield none.
module distance_filter
    import distance_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int LOG2_DEPTH     = 2,
    parameter int MIN_VALID_CM   = 2,
    parameter int MAX_VALID_CM   = 400,
    parameter int TIMEOUT_CYCLES = CLK_HZ
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid,
    output logic [DATA_WIDTH-1:0] filtered_out,
    output logic                  filtered_valid,
    output logic                  out_of_range,
    output logic                  no_echo,
    output logic                  window_full
);

    localparam int WINDOW = 1 << LOG2_DEPTH;
    localparam int SW     = DATA_WIDTH + LOG2_DEPTH;
    localparam int FW     = LOG2_DEPTH + 1;
    localparam int CW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TO_FIRE = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] FILL_WINDOW = FW'(WINDOW);

    logic                  in_range;
    logic                  accept;
    logic                  reject;
    logic                  timeout_fire;
    logic [1:0]            state;
    logic [CW-1:0]         to_cnt;
    logic [SW-1:0]         ring_sum;
    logic [FW-1:0]         ring_fill;
    logic                  accept_d;
    logic                  stale_d;
    logic [DATA_WIDTH-1:0] sample_d;

    assign in_range = (sample_in >= DATA_WIDTH'(MIN_VALID_CM)) &&
                      (sample_in <= DATA_WIDTH'(MAX_VALID_CM));
    assign accept   = sample_valid && in_range;
    assign reject   = sample_valid && !in_range;
    // A strobe in the firing cycle wins: the timeout only fires on an idle cycle.
    assign timeout_fire = !sample_valid && (state != ST_STALE) && (to_cnt == TO_FIRE);

    distance_sample_ring #(
        .DATA_WIDTH (DATA_WIDTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_ring (
        .clk      (clk),
        .reset    (reset),
        .push     (accept),
        .clear    (timeout_fire),
        .data_in  (sample_in),
        .sum      (ring_sum),
        .fill_cnt (ring_fill)
    );

    // Count idle cycles since the last strobe of any kind, holding at the limit
    always_ff @(posedge clk) begin
        if (reset || sample_valid) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // FILL until the window is full, AVG afterwards, STALE on echo loss
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FILL;
        end else if (accept) begin
            state <= ((ring_fill + 1'b1) >= FILL_WINDOW) ? ST_AVG : ST_FILL;
        end else if (timeout_fire) begin
            state <= ST_STALE;
        end
    end

    // Status flags follow the most recent sensor activity
    always_ff @(posedge clk) begin
        if (reset) begin
            out_of_range <= 1'b0;
            no_echo      <= 1'b0;
        end else if (accept) begin
            out_of_range <= 1'b0;
            no_echo      <= 1'b0;
        end else if (reject) begin
            out_of_range <= 1'b1;
        end else if (timeout_fire) begin
            no_echo <= 1'b1;
        end
    end

    // Remember which event the output stage must publish next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            accept_d <= 1'b0;
            stale_d  <= 1'b0;
            sample_d <= '0;
        end else begin
            accept_d <= accept;
            stale_d  <= timeout_fire;
            if (accept) begin
                sample_d <= sample_in;
            end
        end
    end

    // Output register: updates only on accepted samples or a stale event, otherwise holds
    always_ff @(posedge clk) begin
        if (reset) begin
            filtered_out   <= '0;
            filtered_valid <= 1'b0;
            window_full    <= 1'b0;
        end else begin
            filtered_valid <= accept_d || stale_d;
            window_full    <= (state == ST_AVG);
            if (accept_d) begin
                filtered_out <= (state == ST_AVG) ? DATA_WIDTH'(ring_sum >> LOG2_DEPTH) : sample_d;
            end else if (stale_d) begin
                filtered_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_distance_filter.sv
// Purpose: directed bench for distance_filter with a queue-based reference model.
// Latency: expects pulses 2 cycles after each accepted strobe.
// Backpressure: n/a.
module tb_distance_filter;

    localparam int DW  = 16;
    localparam int WIN = 4;
    localparam int TO  = 50;

    logic          clk;
    logic          reset;
    logic [DW-1:0] sample_in;
    logic          sample_valid;
    logic [DW-1:0] filtered_out;
    logic          filtered_valid;
    logic          out_of_range;
    logic          no_echo;
    logic          window_full;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 0;

    distance_filter #(
        .DATA_WIDTH     (DW),
        .LOG2_DEPTH     (2),
        .MIN_VALID_CM   (2),
        .MAX_VALID_CM   (400),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .filtered_out   (filtered_out),
        .filtered_valid (filtered_valid),
        .out_of_range   (out_of_range),
        .no_echo        (no_echo),
        .window_full    (window_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: last WIN accepted samples in a queue, idle counter, stale flag.
    int          win[$];
    int          idle     = 0;
    bit          stale    = 0;
    bit          pend_v   = 0;
    int          pend_val = 0;
    logic [DW-1:0] e_fo  = '0;
    logic          e_fv  = 1'b0;
    logic          e_oor = 1'b0;
    logic          e_ne  = 1'b0;
    logic          e_wf  = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            win.delete();
            idle = 0; stale = 0; pend_v = 0;
            e_fo = '0; e_fv = 0; e_oor = 0; e_ne = 0; e_wf = 0;
        end else begin
            e_wf = (win.size() == WIN);
            e_fv = pend_v;
            if (pend_v) e_fo = pend_val[DW-1:0];
            pend_v = 0;
            if (sample_valid) begin
                idle = 0;
                if (sample_in >= 2 && sample_in <= 400) begin
                    int s;
                    stale = 0;
                    win.push_back(int'(sample_in));
                    if (win.size() > WIN) void'(win.pop_front());
                    s = 0;
                    foreach (win[i]) s += win[i];
                    pend_val = (win.size() == WIN) ? s / WIN : int'(sample_in);
                    pend_v = 1;
                    e_oor = 0;
                    e_ne  = 0;
                end else begin
                    e_oor = 1;
                end
            end else if (!stale) begin
                idle++;
                if (idle == TO) begin
                    stale = 1;
                    win.delete();
                    e_ne = 1;
                    pend_v = 1;
                    pend_val = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_filtered_out",   filtered_out,   e_fo);
            check("model_filtered_valid", filtered_valid, e_fv);
            check("model_out_of_range",   out_of_range,   e_oor);
            check("model_no_echo",        no_echo,        e_ne);
            check("model_window_full",    window_full,    e_wf);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input int v, input bit vld);
        sample_in    = DW'(v);
        sample_valid = vld;
    endtask

    task automatic gap(input int n);
        drive(0, 0);
        repeat (n) tick();
    endtask

    // One strobe, then the pulse must appear exactly 2 cycles later with the given value
    task automatic send_exp(input int v, input int e);
        drive(v, 1);
        tick();
        drive(0, 0);
        tick();
        check("pulse_vld", filtered_valid, 1);
        check("pulse_val", filtered_out, e);
    endtask

    task automatic send_rej(input int v, input int hold);
        drive(v, 1);
        tick();
        drive(0, 0);
        tick();
        check("rej_no_vld", filtered_valid, 0);
        check("rej_hold",   filtered_out, hold);
        check("rej_oor",    out_of_range, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int v5[5];
        int e5[5];
        int at_tick;
        v5 = '{10, 20, 30, 40, 50};
        e5 = '{10, 20, 30, 25, 35};

        reset = 1'b1;
        drive(0, 0);
        repeat (3) tick();
        reset = 1'b0;
        chk_en = 1;
        check("rst_fo",  filtered_out, 0);
        check("rst_fv",  filtered_valid, 0);
        check("rst_oor", out_of_range, 0);
        check("rst_ne",  no_echo, 0);
        check("rst_wf",  window_full, 0);

        // Fill phase then first average
        send_exp(100, 100); gap(3);
        send_exp(104, 104); gap(3);
        send_exp(108, 108);
        check("fill_wf_low", window_full, 0);
        gap(3);
        send_exp(112, 106);
        check("avg_wf_high", window_full, 1);
        gap(3);

        // Wrap-around replacement
        send_exp(116, 110); gap(3);
        send_exp(120, 114); gap(3);

        // Rejections hold the output
        send_rej(0, 114);   gap(3);
        send_rej(1, 114);   gap(3);
        send_rej(500, 114); gap(3);
        send_exp(114, 115);
        check("oor_cleared", out_of_range, 0);

        // Echo loss: pulse 50 idle cycles after the last strobe's pulse point
        at_tick = -1;
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (filtered_valid === 1'b1 && at_tick < 0) begin
                at_tick = i;
                check("stale_fo", filtered_out, 0);
                check("stale_ne", no_echo, 1);
                check("stale_wf", window_full, 0);
            end
        end
        check("stale_pulse_tick", at_tick, 50);
        send_exp(200, 200);
        check("recover_ne", no_echo, 0);
        check("recover_wf", window_full, 0);
        gap(3);

        // Back-to-back strobes from an empty window
        reset = 1'b1; tick(); reset = 1'b0;
        for (int t = 0; t < 7; t++) begin
            if (t < 5) drive(v5[t], 1);
            else drive(0, 0);
            tick();
            if (t >= 1 && t <= 5) begin
                check("b2b_vld", filtered_valid, 1);
                check("b2b_val", filtered_out, e5[t-1]);
            end
        end
        check("b2b_end", filtered_valid, 0);
        gap(3);

        // Reset coinciding with the third strobe
        reset = 1'b1; tick(); reset = 1'b0;
        send_exp(100, 100); gap(3);
        send_exp(104, 104); gap(3);
        drive(108, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(0, 0);
        check("midrst_fo",  filtered_out, 0);
        check("midrst_fv",  filtered_valid, 0);
        check("midrst_oor", out_of_range, 0);
        check("midrst_wf",  window_full, 0);
        tick();
        check("midrst_dropped", filtered_valid, 0);
        gap(3);
        send_exp(100, 100); gap(3);

        // Range boundaries
        send_exp(2, 2);     gap(3);
        send_exp(400, 400); gap(3);
        send_rej(401, 400); gap(3);
        send_exp(399, 225); gap(3);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/distance_filter.md
Name: distance_filter

Overview:
Conditioning stage between the HC-SR04 ultrasonic controller and its consumers (4-digit display, UART debug frame).
- Accepts raw distance samples (cm) with a valid strobe.
- Rejects out-of-range readings.
- Produces a moving average over 2^LOG2_DEPTH accepted samples.
- Flags loss of echo after a programmable timeout.
- Holds its output stable between updates so the display never flickers on bad readings.

Parameters:
DATA_WIDTH, 16, width of distance samples and filtered output
LOG2_DEPTH, 2, log2 of averaging window (window = 4 samples)
MIN_VALID_CM, 2, smallest accepted distance (inclusive)
MAX_VALID_CM, 400, largest accepted distance (inclusive)
TIMEOUT_CYCLES, 12000000, cycles without any sample_valid before no_echo (1 s at 12 MHz)

Ports:
clk  input  1  system clock (12 MHz)
reset  input  1  synchronous, active-high reset
sample_in  input  DATA_WIDTH  raw distance in cm from ultrasonic controller
sample_valid  input  1  single-cycle strobe; sample_in valid this cycle
filtered_out  output  DATA_WIDTH  conditioned distance in cm, held between updates
filtered_valid  output  1  single-cycle pulse when filtered_out updates
out_of_range  output  1  set on rejected sample, cleared on next accepted sample
no_echo  output  1  set on timeout, cleared on next accepted sample
window_full  output  1  high once window holds 2^LOG2_DEPTH samples

Behaviour:
- Reset (sync, active-high, sampled on clk rising edge) clears ring buffer, running sum, write pointer, fill count, timeout counter and state (FILL). All outputs go to 0.
- Reset asserted mid-operation overrides everything at that edge. A sample_valid in the same cycle as reset is dropped.
- Acceptance: sample_valid && MIN_VALID_CM <= sample_in <= MAX_VALID_CM.
- Rejection: sample_valid otherwise.
  - Sets out_of_range at the next edge.
  - No buffer change, no filtered_valid.
  - filtered_out unchanged.
- Running sum is DATA_WIDTH+LOG2_DEPTH bits wide and never overflows.
- On acceptance at edge N:
  - sum <= sum - buf[wr_ptr] + sample_in
  - buf[wr_ptr] <= sample_in
  - wr_ptr increments modulo 2^LOG2_DEPTH
  - fill count saturates at 2^LOG2_DEPTH
  - out_of_range and no_echo clear
- Output stage is registered at edge N+1, so filtered_valid is high during the cycle after N+1. Fixed latency is 2 cycles from the sample_valid cycle.
- States:
  - FILL: fill count < window. filtered_out = most recently accepted raw sample (pass-through). window_full = 0. Moves to AVG when the accept makes fill count = window.
  - AVG: filtered_out = sum >> LOG2_DEPTH (truncating). window_full = 1.
  - STALE: entered from FILL or AVG when the timeout counter reaches TIMEOUT_CYCLES.
    - Sets no_echo.
    - Clears buffer, sum, fill count, wr_ptr.
    - filtered_out forced to 0 with one filtered_valid pulse.
    - Next accepted sample goes to FILL, treated as first sample.
- Timeout counter:
  - Resets to 0 on any sample_valid, accepted or rejected.
  - Otherwise increments, saturating in STALE (no repeated pulses).
  - So no_echo indicates no sensor activity at all. out_of_range indicates activity with bad readings.
- Back-to-back sample_valid on consecutive cycles is fully supported: one filtered_valid per accepted sample, in order, no stalls.
- Sample arriving in the same cycle the timeout would fire: the sample wins, counter resets, no STALE entry.
- Rejected sample at wrap position does not advance wr_ptr.

Decomposition:
- Shared package (distance_pkg): DATA_WIDTH default, state encoding (FILL, AVG, STALE), CLK_HZ = 12000000. The ultrasonic controller and display path reuse the same constants.
- One sub-module, distance_sample_ring: ring buffer, wr_ptr, running sum, fill count. Interface: push, data_in, clear; outputs sum and fill count.
- Top handles range check, timeout, FSM and output register.

Test Plan (LOG2_DEPTH=2, TIMEOUT_CYCLES=50 in bench):
1. Reset, then accept 100,104,108,112 (spaced 5 cycles):
   - filtered_out = 100,104,108,106.
   - window_full rises with 4th pulse.
   - Each pulse 2 cycles after its strobe.
2. Continue with 116, then 120:
   - filtered_out = 110 ((104+108+112+116)>>2), then 114. Confirms wrap-around replacement.
3. In AVG, send 0, 1, 500:
   - No filtered_valid; filtered_out stays 114; out_of_range=1.
   - Then send 114: out_of_range=0, filtered_out = (112+116+120+114)>>2 = 115.
4. No strobes for 50 cycles:
   - no_echo=1; one filtered_valid with filtered_out=0; window_full=0.
   - Then send 200: filtered_out=200, no_echo=0, state FILL.
5. Back-to-back strobes 10,20,30,40,50 on consecutive cycles:
   - Five consecutive filtered_valid pulses with values 10,20,30,25,35.
6. Assert reset for one cycle while a sample_valid is in flight (same cycle as strobe 3 of scenario 1):
   - All outputs 0 next cycle, no filtered_valid for the dropped sample.
   - Next sample 100 passes through as 100.
